// File: rtl/rv_pkg.sv
// Shared constants and state type for the RV32I multi-cycle core sequencer.
package rv_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'h13;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-memory request/response handshake between sequencer and imem.
interface core_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/core_sequencer_pc_unit.sv
// Program counter register: loads RESET_PC on reset, advances by one word on inc.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer; owns PC and traps non-OP-IMM opcodes.
module core_sequencer
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    core_sequencer_if.master    imem,
    output logic [31:0]         instr,
    output logic                alu_en,
    output logic                rf_we,
    output logic [31:0]         pc,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    seq_state_t state;
    seq_state_t state_next;
    logic       retire;
    logic       opc_legal;

    assign retire    = (state == WB);
    assign opc_legal = (instr[6:0] == OPC_OP_IMM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (run) state_next = FETCH;
            FETCH:   if (imem.imem_valid) state_next = DECODE;
            DECODE:  state_next = opc_legal ? EXEC : HALT;
            EXEC:    state_next = WB;
            WB:      state_next = run ? FETCH : IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Instruction capture is gated on FETCH so stray imem_valid pulses never leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr   <= NOP_INSTR;
            retired <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (state == FETCH && imem.imem_valid) begin
                instr <= imem.imem_rdata;
            end
            if (retire) begin
                retired <= retired + RETIRE_W'(1);
            end
            if (state == DECODE && !opc_legal) begin
                halted  <= 1'b1;
                illegal <= 1'b1;
            end
        end
    end

    pc_unit #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .inc (retire),
        .pc  (pc)
    );

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign alu_en         = (state == EXEC);
    assign rf_we          = (state == WB) && (instr[11:7] != 5'd0);

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute and writeback, owns the program counter, and drives the instruction-memory handshake. Produces the per-phase enables consumed by the decode stage, ALU and register file. Traps any opcode other than OP-IMM (7'h13) into a sticky halt.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RETIRE_W, 32, width of the retired-instruction counter

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; permits starting or continuing execution
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address; equals pc while imem_req=1
- imem_valid  in  1  imem_rdata valid this cycle; sampled only in FETCH
- imem_rdata  in  32  fetched instruction word
- instr  out  32  latched instruction presented to decode
- alu_en  out  1  ALU operand/result capture enable
- rf_we  out  1  register-file write enable
- pc  out  32  current program counter
- halted  out  1  sticky; core stopped by illegal opcode
- illegal  out  1  sticky; cause flag for halted
- retired  out  RETIRE_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset values: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), retired=0, imem_req=0, alu_en=0, rf_we=0, halted=0, illegal=0.
- IDLE: all enables 0; run=1 -> FETCH, else stay.
- FETCH: imem_req=1, imem_addr=pc; hold until imem_valid=1; on that edge instr<=imem_rdata -> DECODE. run is not sampled in FETCH; a pending fetch always completes.
- DECODE: one cycle, no enables. instr[6:0]==7'h13 -> EXEC; any other opcode -> HALT with halted<=1, illegal<=1.
- EXEC: alu_en=1 for exactly one cycle -> WB.
- WB: rf_we=1 iff instr[11:7]!=0 (writes to x0 suppressed). On exit pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and retired<=retired+1 (wraps mod 2^RETIRE_W). Then run=1 -> FETCH, run=0 -> IDLE.
- HALT: all enables 0, pc and retired frozen; only rst exits.
- imem_valid outside FETCH is ignored; imem_rdata is never captured outside FETCH.
- pc in HALT holds the address of the illegal instruction.

## Timing
- All outputs registered or decoded from current state only; no combinational path from inputs to outputs.
- imem_valid may assert in the first FETCH cycle (zero-wait memory): instruction takes 4 cycles FETCH, DECODE, EXEC, WB.
- Each cycle of imem_valid=0 in FETCH adds one cycle.
- alu_en and rf_we are each high for at most one cycle per instruction, never simultaneously.
- pc and retired update on the same edge (WB exit); new pc visible in the following FETCH cycle.
- rst asserted in any state, including FETCH with a request outstanding: next edge all state returns to reset values; outstanding request abandoned, a late imem_valid is ignored.
- rst and imem_valid in the same cycle: rst wins, instr takes the NOP reset value.

## Structure
- Shared package rv_pkg: opcode constant OPC_OP_IMM=7'h13, NOP encoding 32'h0000_0013, seq_state_t enum (IDLE, FETCH, DECODE, EXEC, WB, HALT).
- One sub-module: pc_unit (PC register, RESET_PC load, +4 increment on enable).

## Test plan
- Reset, run=1, zero-wait imem returning 32'h0050_0093 (addi x1,x0,5) -> imem_addr=0, alu_en in cycle 3, rf_we in cycle 4, pc=4, retired=1.
- Three back-to-back addi, imem_valid delayed 2 cycles each -> 6 cycles per instruction, pc=12, retired=3.
- Fetch 32'h0000_0013 (addi x0,x0,0) -> rf_we stays 0 in WB, retired increments.
- Fetch 32'h0000_0033 (OP opcode) at pc=8 -> HALT, halted=illegal=1, pc=8, no alu_en/rf_we; run toggling has no effect until rst.
- RESET_PC=32'hFFFF_FFFC, one addi -> pc wraps to 0, next imem_addr=0.
- rst asserted during FETCH with imem_valid the same cycle -> state IDLE, instr=NOP, pc=RESET_PC, retired=0.
